// File: rtl/pixel_job_scheduler.sv
// Round-robin dispatch of per-pixel (x, y) jobs to N_CORES shading cores, with in-order collection re-emitted in raster order.
// Optional macro PIXEL_JOB_SCHEDULER_PERF_EN adds perf_frame_cycles / perf_stall_cycles outputs.
module pixel_job_scheduler #(
  parameter int X_SIZE  = 640,
  parameter int Y_SIZE  = 480,
  parameter int N_CORES = 4,
  parameter int XW      = $clog2(X_SIZE),
  parameter int YW      = $clog2(Y_SIZE)
) (
  input  logic                   aclk,
  input  logic                   areset,
  input  logic                   start,
  input  logic                   continuous,
  output logic                   busy,
  output logic                   frame_done,
  output logic [7:0]             frame_count,
  output logic [N_CORES-1:0]     job_valid,
  input  logic [N_CORES-1:0]     job_ready,
  output logic [XW-1:0]          job_x,
  output logic [YW-1:0]          job_y,
  input  logic [N_CORES-1:0]     res_valid,
  output logic [N_CORES-1:0]     res_ready,
  input  logic [24*N_CORES-1:0]  res_rgb,
  output logic [7:0]             out_r,
  output logic [7:0]             out_g,
  output logic [7:0]             out_b,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic                   out_sof,
  output logic                   out_eol,
`ifdef PIXEL_JOB_SCHEDULER_PERF_EN
  output logic [31:0]            perf_frame_cycles,
  output logic [31:0]            perf_stall_cycles,
`endif
  output logic [1:0]             dbg_state
);

  localparam int CW = (N_CORES > 1) ? $clog2(N_CORES) : 1;
  localparam int IW = $clog2(N_CORES + 1);
  localparam logic [XW-1:0] LAST_X   = XW'(X_SIZE - 1);
  localparam logic [YW-1:0] LAST_Y   = YW'(Y_SIZE - 1);
  localparam logic [CW-1:0] LAST_C   = CW'(N_CORES - 1);
  localparam logic [IW-1:0] MAX_INFL = IW'(N_CORES);

  typedef enum logic [1:0] {S_IDLE = 2'd0, S_RUN = 2'd1, S_DRAIN = 2'd2} state_t;

  state_t        state;
  logic [CW-1:0] dptr, cptr;
  logic [XW-1:0] dx, cx;
  logic [YW-1:0] dy, cy;
  logic [IW-1:0] inflight;

  logic          can_issue, job_fire, active, out_fire;
  logic          last_job, last_out, go, frame_end;
  logic [23:0]   rgb_arr [N_CORES];
  logic [23:0]   rgb_sel;

  assign job_x     = dx;
  assign job_y     = dy;
  assign dbg_state = state;

  // All channels use valid/ready: a transfer happens on a rising edge where both are high;
  // valid never waits on ready, and payload holds while valid is high without ready.
  always_comb begin
    for (int i = 0; i < N_CORES; i++) rgb_arr[i] = res_rgb[24*i +: 24];
    rgb_sel   = rgb_arr[cptr];
    go        = start || continuous;
    can_issue = (state == S_RUN) && (inflight < MAX_INFL);
    job_valid = '0;
    if (can_issue) job_valid[dptr] = 1'b1;
    job_fire  = can_issue && job_ready[dptr];
    active    = (inflight != '0);
    res_ready = '0;
    if (active && out_ready) res_ready[cptr] = 1'b1;
    out_valid = active && res_valid[cptr];
    out_fire  = out_valid && out_ready;
    out_r     = out_valid ? rgb_sel[23:16] : 8'd0;
    out_g     = out_valid ? rgb_sel[15:8]  : 8'd0;
    out_b     = out_valid ? rgb_sel[7:0]   : 8'd0;
    out_sof   = out_valid && (cx == '0) && (cy == '0);
    out_eol   = out_valid && (cx == LAST_X);
    last_job  = (dx == LAST_X) && (dy == LAST_Y);
    last_out  = (cx == LAST_X) && (cy == LAST_Y);
    frame_end = (state == S_DRAIN) && out_fire && last_out;
  end

  always_ff @(posedge aclk) begin
    if (areset) begin
      state       <= S_IDLE;
      dptr        <= '0;
      cptr        <= '0;
      dx          <= '0;
      dy          <= '0;
      cx          <= '0;
      cy          <= '0;
      inflight    <= '0;
      busy        <= 1'b0;
      frame_done  <= 1'b0;
      frame_count <= 8'd0;
    end else begin
      frame_done <= 1'b0;
      busy       <= (state != S_IDLE) || go;
      if (job_fire) begin
        dptr <= (dptr == LAST_C) ? '0 : dptr + 1'b1;
        if (dx == LAST_X) begin
          dx <= '0;
          dy <= dy + 1'b1;
        end else begin
          dx <= dx + 1'b1;
        end
        if (last_job) state <= S_DRAIN;
      end
      if (out_fire) begin
        cptr <= (cptr == LAST_C) ? '0 : cptr + 1'b1;
        if (cx == LAST_X) begin
          cx <= '0;
          cy <= cy + 1'b1;
        end else begin
          cx <= cx + 1'b1;
        end
      end
      inflight <= inflight + IW'(job_fire) - IW'(out_fire);
      // Frame start (from IDLE, or back-to-back after the last pixel) zeroes pointers and coords.
      if (((state == S_IDLE) && go) || frame_end) begin
        dptr     <= '0;
        cptr     <= '0;
        dx       <= '0;
        dy       <= '0;
        cx       <= '0;
        cy       <= '0;
        inflight <= '0;
        state    <= ((state == S_IDLE) || continuous) ? S_RUN : S_IDLE;
      end
      if (frame_end) begin
        frame_done  <= 1'b1;
        frame_count <= frame_count + 8'd1;
      end
    end
  end

`ifdef PIXEL_JOB_SCHEDULER_PERF_EN
  logic [31:0] cyc_cnt, stall_cnt;
  logic        stall_now;

  assign stall_now = active && !out_valid;

  always_ff @(posedge aclk) begin
    if (areset) begin
      cyc_cnt           <= 32'd0;
      stall_cnt         <= 32'd0;
      perf_frame_cycles <= 32'd0;
      perf_stall_cycles <= 32'd0;
    end else if (state == S_IDLE) begin
      cyc_cnt   <= 32'd0;
      stall_cnt <= 32'd0;
    end else if (frame_end) begin
      perf_frame_cycles <= cyc_cnt + 32'd1;
      perf_stall_cycles <= stall_cnt + 32'(stall_now);
      cyc_cnt           <= 32'd0;
      stall_cnt         <= 32'd0;
    end else begin
      cyc_cnt   <= cyc_cnt + 32'd1;
      stall_cnt <= stall_cnt + 32'(stall_now);
    end
  end
`endif

endmodule

// File: doc/pixel_job_scheduler.md
Name: pixel_job_scheduler

Overview:
- Sequences one video frame of per-pixel jobs (x, y) across N_CORES parallel shading/ray-march cores.
- Dispatch is round-robin. Results are collected in the same strict order and re-emitted in raster order, with sof/eol, to the pixel packer's input side.
- Sits between the register-file control (start/continuous/frame) and the packer. Replaces the fixed per-pixel colour expression with a multi-core, variable-latency datapath.

Parameters:
- X_SIZE, 640, pixels per line.
- Y_SIZE, 480, lines per frame.
- N_CORES, 4, number of shading cores (1..8).
- XW, $clog2(X_SIZE), x coordinate width (10).
- YW, $clog2(Y_SIZE), y coordinate width (9).

Ports:
- aclk  in  1  stream clock; all logic on its rising edge.
- areset  in  1  synchronous, active-high reset.
- start  in  1  pulse: begin one frame when idle.
- continuous  in  1  level: begin next frame automatically after each frame completes.
- busy  out  1  high from frame start until last pixel collected.
- frame_done  out  1  one-cycle pulse when last pixel of a frame is accepted downstream.
- frame_count  out  8  frames completed; wraps 255->0.
- job_valid  out  N_CORES  one-hot job offer to core dptr.
- job_ready  in  N_CORES  per-core job accept.
- job_x  out  XW  x of offered job (shared by all cores).
- job_y  out  YW  y of offered job (shared by all cores).
- res_valid  in  N_CORES  per-core result available.
- res_ready  out  N_CORES  one-hot result accept to core cptr.
- res_rgb  in  24*N_CORES  core i result at [24*i+:24], {r,g,b}.
- out_r, out_g, out_b  out  8 each  pixel to packer (combinational from res_rgb[cptr]).
- out_valid  out  1  pixel valid.
- out_ready  in  1  packer ready.
- out_sof  out  1  high with pixel (0,0).
- out_eol  out  1  high with pixel x==X_SIZE-1.

Behaviour:
- Reset: all outputs 0. State IDLE; dptr=cptr=0; dispatch/collect coords (0,0); inflight=0; frame_count=0. Cores are expected to be reset alongside.
- States:
  - IDLE -> RUN on start|continuous. Coords and pointers are zeroed on entry; busy=1.
  - RUN -> DRAIN on the cycle the job (X_SIZE-1, Y_SIZE-1) is accepted.
  - DRAIN -> (frame_done pulse) on acceptance of the last output pixel. Next state is RUN (new frame, same cycle as the pulse) if continuous=1, else IDLE.
- Dispatch, RUN only:
  - job_valid[dptr]=1 iff inflight<N_CORES; job_x/job_y = dispatch coords.
  - Handshake = job_valid[dptr]&job_ready[dptr]. On handshake: dptr wraps N_CORES-1->0; x advances, wrapping at X_SIZE-1 to 0 with y+1; inflight+1.
  - job_x/job_y stay stable while job_valid is held without ready.
- Collection, RUN or DRAIN:
  - out_valid = res_valid[cptr] & (inflight!=0); res_ready[cptr] = out_ready & (inflight!=0); all other res_ready bits 0.
  - On out_valid&out_ready: cptr wraps; collect coords advance as above; inflight-1.
  - out_sof/out_eol are decoded from collect coords.
  - res_valid on any core other than cptr is ignored.
- Simultaneous dispatch and collect: inflight unchanged. inflight never exceeds N_CORES, so each core holds at most one job and in-order collection is exact.
- start while busy: ignored.
- continuous deasserted mid-frame: current frame completes, then IDLE.
- Latency:
  - First job_valid appears the cycle after start is sampled in IDLE.
  - The output path has zero added latency (combinational mux).
- Reset mid-frame: immediate return to IDLE; no frame_done; frame_count cleared.

Optional Feature:
- Macro PIXEL_JOB_SCHEDULER_PERF_EN.
- When defined, adds two outputs:
  - perf_frame_cycles (32): cycles from RUN entry to frame_done.
  - perf_stall_cycles (32): cycles in RUN/DRAIN with inflight!=0 and out_valid=0.
- Both counters are latched on frame_done and cleared on reset.
- Undefined: ports and counters are absent; behaviour is otherwise identical.

Test Plan:
- X_SIZE=4, Y_SIZE=2, N_CORES=2, cores return rgb={x,y,x^y} after 1 cycle, out_ready=1, start pulse -> 8 pixels in raster order; sof only on (0,0); eol on x=3; frame_done once; frame_count=1; busy falls the cycle after frame_done.
- Same setup, core 1 latency 5 cycles, core 0 latency 1 -> output order still raster; inflight never >2; no res_ready to core 0 while cptr=1.
- out_ready held 0 for 20 cycles mid-frame -> job_valid drops after 2 outstanding jobs; out_r/g/b/valid stable; resumes with no lost or duplicated pixels.
- continuous=1 for 3 frames -> frame_done pulses 3 times; frame_count 1,2,3; next RUN entered same cycle as each frame_done with no idle gap.
- areset asserted after 5 outputs -> next cycle all outputs 0, state IDLE, frame_count=0; a subsequent start produces a full correct frame from (0,0).
- frame_count at 255 + one more frame -> wraps to 0; with PIXEL_JOB_SCHEDULER_PERF_EN, perf_frame_cycles equals the measured cycle count.
